alarm_clock_setter: RTL and testbench



---
 rtl/alarm_clock_setter.sv | 148 ++++++++++++++
 tb/tb_alarm_clock_setter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_setter.sv
// alarm_clock_setter: button-driven front end for the alarm clock core.
// Turns one-cycle button pulses into an edit/commit state machine that
// produces BCD hour/minute digits, load strobes, STOP_al and AL_ON.
// Optional macro ALARM_AUTO_STOP_EN adds an automatic alarm stop after
// ALARM_TIMEOUT cycles of alarm_in held high.
module alarm_clock_setter #(
  parameter int ALARM_TIMEOUT = 60
) (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_hour,
  input  logic       btn_min,
  input  logic       btn_set,
  input  logic       btn_al,
  input  logic       btn_stop,
  input  logic       alarm_in,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic [1:0] mode_out
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SET_TIME  = 2'b01,
    SET_ALARM = 2'b10,
    COMMIT    = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [1:0] hour_tens_nxt;
  logic [3:0] hour_units_nxt;
  logic [3:0] min_tens_nxt;
  logic [3:0] min_units_nxt;
  logic       ld_time_nxt;
  logic       ld_alarm_nxt;
  logic       stop_nxt;
  logic       al_on_nxt;
  logic       edit_en;
  logic       auto_stop;

  // Edits are accepted only while editing and only when no commit is taken.
  assign edit_en = ((state == SET_TIME) || (state == SET_ALARM)) && !btn_set;

  // State register.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state selection; btn_set outranks btn_mode in the edit states.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (btn_mode) state_nxt = SET_TIME;
      SET_TIME:  if (btn_set) state_nxt = COMMIT;
                 else if (btn_mode) state_nxt = SET_ALARM;
      SET_ALARM: if (btn_set) state_nxt = COMMIT;
                 else if (btn_mode) state_nxt = IDLE;
      COMMIT:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Next output values: BCD edit digits with wrap, strobes and alarm enable.
  always_comb begin
    hour_tens_nxt  = H_in1;
    hour_units_nxt = H_in0;
    min_tens_nxt   = M_in1;
    min_units_nxt  = M_in0;
    if (edit_en && btn_hour) begin
      if (H_in1 == 2'd2 && H_in0 == 4'd3) begin
        hour_tens_nxt  = 2'd0;
        hour_units_nxt = 4'd0;
      end else if (H_in0 == 4'd9) begin
        hour_tens_nxt  = H_in1 + 2'd1;
        hour_units_nxt = 4'd0;
      end else begin
        hour_units_nxt = H_in0 + 4'd1;
      end
    end
    if (edit_en && btn_min) begin
      if (M_in0 == 4'd9) begin
        min_units_nxt = 4'd0;
        min_tens_nxt  = (M_in1 == 4'd5) ? 4'd0 : M_in1 + 4'd1;
      end else begin
        min_units_nxt = M_in0 + 4'd1;
      end
    end
    ld_time_nxt  = (state == SET_TIME) && btn_set;
    ld_alarm_nxt = (state == SET_ALARM) && btn_set;
    stop_nxt     = btn_stop || auto_stop;
    al_on_nxt    = AL_ON ^ ((state == IDLE) && btn_al);
  end

  // Output registers; reset discards any strobe that was about to be issued.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      H_in1    <= 2'd0;
      H_in0    <= 4'd0;
      M_in1    <= 4'd0;
      M_in0    <= 4'd0;
      LD_time  <= 1'b0;
      LD_alarm <= 1'b0;
      STOP_al  <= 1'b0;
      AL_ON    <= 1'b0;
      mode_out <= 2'b00;
    end else begin
      H_in1    <= hour_tens_nxt;
      H_in0    <= hour_units_nxt;
      M_in1    <= min_tens_nxt;
      M_in0    <= min_units_nxt;
      LD_time  <= ld_time_nxt;
      LD_alarm <= ld_alarm_nxt;
      STOP_al  <= stop_nxt;
      AL_ON    <= al_on_nxt;
      mode_out <= state_nxt;
    end
  end

`ifdef ALARM_AUTO_STOP_EN
  localparam int CNT_W = $clog2(ALARM_TIMEOUT + 1);

  logic [CNT_W-1:0] alarm_cnt;

  assign auto_stop = (alarm_cnt == CNT_W'(ALARM_TIMEOUT));

  // Count cycles of a ringing alarm; any stop or a quiet alarm restarts it.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset)                   alarm_cnt <= '0;
    else if (!alarm_in || stop_nxt) alarm_cnt <= '0;
    else                         alarm_cnt <= alarm_cnt + CNT_W'(1);
  end
`else
  logic unused_alarm;

  assign auto_stop    = 1'b0;
  assign unused_alarm = alarm_in & (ALARM_TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_alarm_clock_setter.sv
// tb_alarm_clock_setter: directed self-checking bench for alarm_clock_setter.
module tb_alarm_clock_setter;

  logic       clk_1s = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_hour = 1'b0, btn_min = 1'b0;
  logic       btn_set = 1'b0, btn_al = 1'b0, btn_stop = 1'b0;
  logic       alarm_in = 1'b0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, STOP_al, AL_ON;
  logic [1:0] mode_out;

  int checks = 0;
  int failures = 0;

  // Button masks, ordered {mode, hour, min, set, al, stop}.
  localparam logic [5:0] B_NONE = 6'b000000;
  localparam logic [5:0] B_MODE = 6'b100000;
  localparam logic [5:0] B_HOUR = 6'b010000;
  localparam logic [5:0] B_MIN  = 6'b001000;
  localparam logic [5:0] B_SET  = 6'b000100;
  localparam logic [5:0] B_AL   = 6'b000010;
  localparam logic [5:0] B_STOP = 6'b000001;

  alarm_clock_setter #(.ALARM_TIMEOUT(5)) dut (
    .clk_1s(clk_1s), .reset(reset),
    .btn_mode(btn_mode), .btn_hour(btn_hour), .btn_min(btn_min),
    .btn_set(btn_set), .btn_al(btn_al), .btn_stop(btn_stop),
    .alarm_in(alarm_in),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al),
    .AL_ON(AL_ON), .mode_out(mode_out)
  );

  // Free-running 1 s clock stand-in.
  always #5 clk_1s = ~clk_1s;

  // Drive buttons for one clock edge, then release them 1 time unit after.
  task automatic applyStimulus(input logic [5:0] btns);
    {btn_mode, btn_hour, btn_min, btn_set, btn_al, btn_stop} = btns;
    @(posedge clk_1s);
    #1;
    {btn_mode, btn_hour, btn_min, btn_set, btn_al, btn_stop} = B_NONE;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkTime(input string tag, input logic [3:0] h1, input logic [3:0] h0,
                           input logic [3:0] m1, input logic [3:0] m0);
    checkOutput({tag, ".H_in1"}, {2'b00, H_in1}, h1);
    checkOutput({tag, ".H_in0"}, H_in0, h0);
    checkOutput({tag, ".M_in1"}, M_in1, m1);
    checkOutput({tag, ".M_in0"}, M_in0, m0);
  endtask

  task automatic checkFlags(input string tag, input logic [1:0] mode, input logic ldt,
                            input logic lda, input logic stop, input logic alon);
    checkOutput({tag, ".mode_out"}, {2'b00, mode_out}, {2'b00, mode});
    checkOutput({tag, ".LD_time"}, {3'b000, LD_time}, {3'b000, ldt});
    checkOutput({tag, ".LD_alarm"}, {3'b000, LD_alarm}, {3'b000, lda});
    checkOutput({tag, ".STOP_al"}, {3'b000, STOP_al}, {3'b000, stop});
    checkOutput({tag, ".AL_ON"}, {3'b000, AL_ON}, {3'b000, alon});
  endtask

  initial begin
    $display("[TB] starting alarm_clock_setter directed test");

    // Reset state
    @(posedge clk_1s);
    @(posedge clk_1s);
    #1;
    checkTime("reset", 0, 0, 0, 0);
    checkFlags("reset", 2'b00, 0, 0, 0, 0);
    reset = 1'b0;

    // Asynchronous reset in the middle of SET_TIME with hour 5
    applyStimulus(B_MODE);
    repeat (5) applyStimulus(B_HOUR);
    checkTime("pre_reset", 0, 5, 0, 0);
    checkOutput("pre_reset.mode_out", {2'b00, mode_out}, 4'd1);
    reset = 1'b1;
    #1;
    checkTime("async_reset", 0, 0, 0, 0);
    checkFlags("async_reset", 2'b00, 0, 0, 0, 0);
    reset = 1'b0;

    // 25 hours and 61 minutes wrap to 01:01, then commit as time
    applyStimulus(B_MODE);
    checkFlags("set_time", 2'b01, 0, 0, 0, 0);
    repeat (25) applyStimulus(B_HOUR);
    repeat (61) applyStimulus(B_MIN);
    checkTime("wrap_edit", 0, 1, 0, 1);
    applyStimulus(B_SET);
    checkFlags("commit_time", 2'b11, 1, 0, 0, 0);
    checkTime("commit_time", 0, 1, 0, 1);
    applyStimulus(B_NONE);
    checkFlags("after_time", 2'b00, 0, 0, 0, 0);
    checkTime("after_time", 0, 1, 0, 1);

    // Boundary 23:59: minute wraps without carry, then hour wraps
    applyStimulus(B_MODE);
    repeat (22) applyStimulus(B_HOUR);
    repeat (58) applyStimulus(B_MIN);
    checkTime("at_2359", 2, 3, 5, 9);
    applyStimulus(B_MIN);
    checkTime("min_wrap", 2, 3, 0, 0);
    applyStimulus(B_HOUR);
    checkTime("hour_wrap", 0, 0, 0, 0);

    // Abort from SET_ALARM back to IDLE without a strobe
    applyStimulus(B_MODE);
    checkFlags("set_alarm", 2'b10, 0, 0, 0, 0);
    applyStimulus(B_MODE);
    checkFlags("abort", 2'b00, 0, 0, 0, 0);
    applyStimulus(B_NONE);
    checkFlags("abort_next", 2'b00, 0, 0, 0, 0);

    // Set alarm to 07:30 and commit
    applyStimulus(B_MODE);
    applyStimulus(B_MODE);
    checkOutput("alarm_mode", {2'b00, mode_out}, 4'd2);
    repeat (7) applyStimulus(B_HOUR);
    repeat (30) applyStimulus(B_MIN);
    applyStimulus(B_SET);
    checkFlags("commit_alarm", 2'b11, 0, 1, 0, 0);
    checkTime("commit_alarm", 0, 7, 3, 0);
    applyStimulus(B_NONE);
    checkFlags("after_alarm", 2'b00, 0, 0, 0, 0);

    // btn_set + btn_mode + btn_hour together at hour 4: set wins, no increment
    applyStimulus(B_MODE);
    repeat (21) applyStimulus(B_HOUR);
    checkTime("hour4", 0, 4, 3, 0);
    applyStimulus(B_SET | B_MODE | B_HOUR);
    checkFlags("prio", 2'b11, 1, 0, 0, 0);
    checkTime("prio", 0, 4, 3, 0);
    applyStimulus(B_NONE);

    // Increments apply alongside btn_mode, and hour+minute in one cycle
    applyStimulus(B_MODE);
    applyStimulus(B_HOUR | B_MIN);
    checkTime("dual_inc", 0, 5, 3, 1);
    applyStimulus(B_MODE | B_MIN);
    checkOutput("mode_inc.mode_out", {2'b00, mode_out}, 4'd2);
    checkTime("mode_inc", 0, 5, 3, 2);
    applyStimulus(B_MODE);

    // Alarm enable toggles only in IDLE; other edit buttons ignored in IDLE
    applyStimulus(B_AL);
    checkFlags("al_on", 2'b00, 0, 0, 0, 1);
    applyStimulus(B_HOUR | B_MIN | B_SET);
    checkFlags("idle_ignore", 2'b00, 0, 0, 0, 1);
    checkTime("idle_ignore", 0, 5, 3, 2);
    applyStimulus(B_MODE);
    applyStimulus(B_AL);
    checkFlags("al_in_set", 2'b01, 0, 0, 0, 1);
    applyStimulus(B_MODE);
    applyStimulus(B_MODE);
    applyStimulus(B_AL);
    checkFlags("al_off", 2'b00, 0, 0, 0, 0);

    // STOP_al follows btn_stop one-for-one
    applyStimulus(B_STOP);
    checkOutput("stop_single", {3'b000, STOP_al}, 4'd1);
    applyStimulus(B_NONE);
    checkOutput("stop_clear", {3'b000, STOP_al}, 4'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(B_STOP);
      checkOutput("stop_held", {3'b000, STOP_al}, 4'd1);
    end
    applyStimulus(B_NONE);
    checkOutput("stop_release", {3'b000, STOP_al}, 4'd0);

    // alarm_in held high for 8 cycles
    alarm_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(B_NONE);
`ifdef ALARM_AUTO_STOP_EN
      checkOutput("auto_stop", {3'b000, STOP_al}, (k == 6) ? 4'd1 : 4'd0);
`else
      checkOutput("no_auto_stop", {3'b000, STOP_al}, 4'd0);
`endif
    end
    alarm_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
